// File: rtl/lampFPU_pkg.sv
// Shared definitions for the lamp FPU square-root unit: bias derivation,
// FSM state encoding and the special-result exponent/fraction constants.
package lampFPU_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } sqrt_state_t;

  function automatic int bias_of(input int e_dw);
    return (1 << (e_dw - 1)) - 1;
  endfunction

  // Exponent field of Inf and NaN: all ones.
  function automatic int exp_all_ones(input int e_dw);
    return (1 << e_dw) - 1;
  endfunction

  // Quiet NaN: fraction MSB set, rest zero.
  function automatic int qnan_frac(input int f_dw);
    return 1 << (f_dw - 1);
  endfunction

  function automatic int iter_count(input int f_dw, input int bpc);
    return (f_dw + 4 + bpc - 1) / bpc;
  endfunction

  localparam int INF_FRAC  = 0;
  localparam int ZERO_EXP  = 0;
  localparam int ZERO_FRAC = 0;

endpackage

// File: rtl/lamp_fpu_sqrt_iter_step.sv
// One restoring square-root recurrence bit: brings in the next radicand bit
// pair, trial-subtracts (4*root + 1) and appends the resulting root bit.
module lamp_fpu_sqrt_step #(
  parameter int RT_W = 11
) (
  input  logic [RT_W+1:0] rem,
  input  logic [RT_W-1:0] root,
  input  logic [1:0]      pair,
  output logic [RT_W+1:0] rem_next,
  output logic [RT_W-1:0] root_next
);

  logic [RT_W+3:0] shifted;
  logic [RT_W+3:0] trial;
  logic            fits;

  always_comb begin
    shifted = {rem, pair};
    trial   = {2'b00, root, 2'b01};
    fits    = (shifted >= trial);
    // The true difference always fits RT_W+2 bits, so the low slice is exact.
    if (fits) begin
      rem_next = shifted[RT_W+1:0] - trial[RT_W+1:0];
    end else begin
      rem_next = shifted[RT_W+1:0];
    end
    root_next = {root[RT_W-2:0], fits};
  end

endmodule

// File: rtl/lamp_fpu_sqrt_iter.sv
// Iterative floating-point square root (restoring recurrence, BITS_PER_CYCLE
// root bits per cycle). Define LAMP_FPU_SQRT_DENORM_EN to normalise subnormals.
module lamp_fpu_sqrt_iter
  import lampFPU_pkg::*;
#(
  parameter int E_DW           = 8,
  parameter int F_DW           = 7,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            doSqrt_i,
  output logic            ready_o,
  input  logic            signum_op_i,
  input  logic [E_DW-1:0] extExp_op_i,
  input  logic [F_DW:0]   extMant_op_i,
  input  logic            isInf_op_i,
  input  logic            isZero_op_i,
  input  logic            isSNAN_op_i,
  input  logic            isQNAN_op_i,
  output logic            valid_o,
  output logic            s_res_o,
  output logic [E_DW-1:0] e_res_o,
  output logic [F_DW+4:0] f_res_o,
  output logic            isToRound_o,
  output logic            invalid_o
);

  localparam int M     = F_DW + 4;
  localparam int N     = iter_count(F_DW, BITS_PER_CYCLE);
  localparam int MP    = N * BITS_PER_CYCLE;
  localparam int RAD_W = 2 * MP;
  localparam int RW    = MP + 2;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [E_DW:0]   BIAS    = (E_DW+1)'(bias_of(E_DW));
  localparam logic [E_DW-1:0] EXP_MAX = E_DW'(exp_all_ones(E_DW));
  localparam logic [E_DW-1:0] EXP_ZRO = E_DW'(ZERO_EXP);
  localparam logic [F_DW+4:0] F_QNAN  = {1'b0, F_DW'(qnan_frac(F_DW)), 4'b0000};
  localparam logic [F_DW+4:0] F_INF   = (F_DW+5)'(INF_FRAC);
  localparam logic [F_DW+4:0] F_ZRO   = (F_DW+5)'(ZERO_FRAC);

  sqrt_state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [RAD_W-1:0] rad_q;
  logic [RW-1:0]    rem_q;
  logic [MP-1:0]    root_q;
  logic [E_DW-1:0]  exp_q;
  logic             spec_q, spec_s_q, spec_inv_q;
  logic [E_DW-1:0]  spec_e_q;
  logic [F_DW+4:0]  spec_f_q;

  logic             is_sub, sub_flush, take_denorm;
  logic             special, sp_s, sp_inv;
  logic [E_DW-1:0]  sp_e;
  logic [F_DW+4:0]  sp_f;
  logic [E_DW:0]    exp_eff, e_sum;
  logic [F_DW:0]    mant_n;
  logic [RAD_W-1:0] rad_c;
  logic [MP-1:0]    root_low;
  logic             sticky;

  assign is_sub  = (extExp_op_i == '0) && (extMant_op_i != '0);
  assign ready_o = (state_q == IDLE);

`ifdef LAMP_FPU_SQRT_DENORM_EN
  localparam int LZ_W = $clog2(F_DW + 2);
  logic [F_DW:0]   mant_q;
  logic [LZ_W-1:0] lz;

  always_ff @(posedge clk) begin
    if (rst) begin
      mant_q <= '0;
    end else if (state_q == IDLE && doSqrt_i) begin
      mant_q <= extMant_op_i;
    end
  end

  // Ascending scan leaves the position of the highest set bit.
  always_comb begin
    lz = '0;
    for (int i = 0; i <= F_DW; i++) begin
      if (mant_q[i]) lz = LZ_W'(F_DW - i);
    end
    if (state_q == NORM) begin
      exp_eff = (E_DW+1)'(1) - (E_DW+1)'(lz);
      mant_n  = mant_q << lz;
    end else begin
      exp_eff = {1'b0, extExp_op_i};
      mant_n  = extMant_op_i;
    end
  end

  assign sub_flush   = 1'b0;
  assign take_denorm = is_sub && !special;
`else
  assign exp_eff     = {1'b0, extExp_op_i};
  assign mant_n      = extMant_op_i;
  assign sub_flush   = is_sub;
  assign take_denorm = 1'b0;
`endif

  // Parity of (exp + BIAS) equals parity of the unbiased exponent.
  always_comb begin
    e_sum = exp_eff + BIAS;
    rad_c = {1'b0, mant_n, {(RAD_W-F_DW-2){1'b0}}};
    if (e_sum[0]) rad_c = rad_c << 1;
  end

  always_comb begin
    special = 1'b1;
    sp_s    = 1'b0;
    sp_e    = EXP_MAX;
    sp_f    = F_QNAN;
    sp_inv  = 1'b0;
    if (isSNAN_op_i || isQNAN_op_i) begin
      sp_inv = isSNAN_op_i;
    end else if (isZero_op_i || sub_flush) begin
      sp_s = signum_op_i;
      sp_e = EXP_ZRO;
      sp_f = F_ZRO;
    end else if (signum_op_i) begin
      sp_inv = 1'b1;
    end else if (isInf_op_i) begin
      sp_f = F_INF;
    end else begin
      special = 1'b0;
    end
  end

  logic [RW-1:0] rem_c  [0:BITS_PER_CYCLE];
  logic [MP-1:0] root_c [0:BITS_PER_CYCLE];

  assign rem_c[0]  = rem_q;
  assign root_c[0] = root_q;

  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    lamp_fpu_sqrt_step #(.RT_W(MP)) u_step (
      .rem       (rem_c[k]),
      .root      (root_c[k]),
      .pair      (rad_q[RAD_W-1-2*k -: 2]),
      .rem_next  (rem_c[k+1]),
      .root_next (root_c[k+1])
    );
  end

  // Root bits below the kept M come from padding when BITS_PER_CYCLE does not divide M.
  assign root_low = root_q << M;
  assign sticky   = (rem_q != '0) || (root_low != '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (doSqrt_i) state_d = special ? DONE : (take_denorm ? NORM : ITER);
      NORM: state_d = ITER;
      ITER: if (cnt_q == '0) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      exp_q       <= '0;
      spec_q      <= 1'b0;
      spec_s_q    <= 1'b0;
      spec_e_q    <= '0;
      spec_f_q    <= '0;
      spec_inv_q  <= 1'b0;
      valid_o     <= 1'b0;
      s_res_o     <= 1'b0;
      e_res_o     <= '0;
      f_res_o     <= '0;
      isToRound_o <= 1'b0;
      invalid_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state_q)
        IDLE: if (doSqrt_i) begin
          spec_q     <= special;
          spec_s_q   <= sp_s;
          spec_e_q   <= sp_e;
          spec_f_q   <= sp_f;
          spec_inv_q <= sp_inv;
          rad_q      <= rad_c;
          exp_q      <= e_sum[E_DW:1];
          rem_q      <= '0;
          root_q     <= '0;
          cnt_q      <= CNT_W'(N - 1);
        end
        NORM: begin
          rad_q  <= rad_c;
          exp_q  <= e_sum[E_DW:1];
          rem_q  <= '0;
          root_q <= '0;
          cnt_q  <= CNT_W'(N - 1);
        end
        ITER: begin
          rad_q  <= rad_q << (2 * BITS_PER_CYCLE);
          rem_q  <= rem_c[BITS_PER_CYCLE];
          root_q <= root_c[BITS_PER_CYCLE];
          cnt_q  <= cnt_q - 1'b1;
        end
        DONE: begin
          valid_o <= 1'b1;
          if (spec_q) begin
            s_res_o     <= spec_s_q;
            e_res_o     <= spec_e_q;
            f_res_o     <= spec_f_q;
            isToRound_o <= 1'b0;
            invalid_o   <= spec_inv_q;
          end else begin
            s_res_o     <= 1'b0;
            e_res_o     <= exp_q;
            f_res_o     <= {root_q[MP-1 -: M], sticky};
            isToRound_o <= 1'b1;
            invalid_o   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lamp_fpu_sqrt_iter.sv
// Directed bench for lamp_fpu_sqrt_iter (default build) plus a 2-bits-per-cycle
// instance checked on sqrt(2.0).
module tb_lamp_fpu_sqrt_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        do_sqrt;
  logic        sgn;
  logic [7:0]  exp_in;
  logic [7:0]  mant_in;
  logic        is_inf, is_zero, is_snan, is_qnan;

  logic        ready1, valid1, s1, rnd1, inv1;
  logic [7:0]  e1;
  logic [11:0] f1;
  logic        ready2, valid2, s2, rnd2, inv2;
  logic [7:0]  e2;
  logic [11:0] f2;

  int n_checks = 0;
  int n_fail   = 0;
  int lat, lat2, seen;

  always #5 clk = ~clk;

  lamp_fpu_sqrt_iter dut (
    .clk(clk), .rst(rst), .doSqrt_i(do_sqrt), .ready_o(ready1),
    .signum_op_i(sgn), .extExp_op_i(exp_in), .extMant_op_i(mant_in),
    .isInf_op_i(is_inf), .isZero_op_i(is_zero), .isSNAN_op_i(is_snan), .isQNAN_op_i(is_qnan),
    .valid_o(valid1), .s_res_o(s1), .e_res_o(e1), .f_res_o(f1),
    .isToRound_o(rnd1), .invalid_o(inv1)
  );

  lamp_fpu_sqrt_iter #(.BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .doSqrt_i(do_sqrt), .ready_o(ready2),
    .signum_op_i(sgn), .extExp_op_i(exp_in), .extMant_op_i(mant_in),
    .isInf_op_i(is_inf), .isZero_op_i(is_zero), .isSNAN_op_i(is_snan), .isQNAN_op_i(is_qnan),
    .valid_o(valid2), .s_res_o(s2), .e_res_o(e2), .f_res_o(f2),
    .isToRound_o(rnd2), .invalid_o(inv2)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic s, input logic [7:0] e, input logic [7:0] m,
                        input logic inf, input logic zero, input logic snan, input logic qnan);
    sgn = s; exp_in = e; mant_in = m;
    is_inf = inf; is_zero = zero; is_snan = snan; is_qnan = qnan;
  endtask

  task automatic issue();
    do_sqrt = 1'b1;
    @(posedge clk); #1;
    do_sqrt = 1'b0;
  endtask

  // Edges counted from the accepting edge; -1 if no pulse within the budget.
  task automatic wait_valid(input bit second, output int l);
    l = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (second ? valid2 : valid1) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic run_special(input string tag, input logic s, input logic [7:0] e,
                             input logic [7:0] m, input logic inf, input logic zero,
                             input logic snan, input logic qnan, input logic xs,
                             input logic [7:0] xe, input logic [11:0] xf, input logic xinv);
    int l;
    set_op(s, e, m, inf, zero, snan, qnan);
    issue();
    wait_valid(1'b0, l);
    check_val({tag, "_lat"}, l, 1);
    check_val({tag, "_s"}, s1, xs);
    check_val({tag, "_e"}, e1, xe);
    check_val({tag, "_f"}, f1, xf);
    check_val({tag, "_inv"}, inv1, xinv);
    check_val({tag, "_rnd"}, rnd1, 0);
  endtask

  initial begin
    rst = 1'b1;
    do_sqrt = 1'b0;
    set_op(0, 8'h00, 8'h00, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_val("rst_ready", ready1, 1);
    check_val("rst_valid", valid1, 0);
    check_val("rst_e", e1, 0);
    check_val("rst_f", f1, 0);
    check_val("rst_rnd", rnd1, 0);
    check_val("rst_inv", inv1, 0);
    check_val("rst_s", s1, 0);

    // sqrt(2.0) on both widths
    set_op(0, 8'h80, 8'h80, 0, 0, 0, 0);
    issue();
    check_val("busy_ready", ready1, 0);
    wait_valid(1'b1, lat2);
    check_val("bpc2_lat", lat2, 7);
    check_val("bpc2_f", f2, 12'hB51);
    check_val("bpc2_e", e2, 8'h7F);
    wait_valid(1'b0, lat);
    check_val("sqrt2_lat", lat + lat2, 12);
    check_val("sqrt2_f", f1, 12'hB51);
    check_val("sqrt2_e", e1, 8'h7F);
    @(posedge clk); #1;
    check_val("pulse_low", valid1, 0);
    check_val("hold_f", f1, 12'hB51);

    set_op(0, 8'h81, 8'h80, 0, 0, 0, 0);
    issue();
    wait_valid(1'b0, lat);
    check_val("sqrt4_lat", lat, 12);
    check_val("sqrt4_e", e1, 8'h80);
    check_val("sqrt4_f", f1, 12'h800);
    check_val("sqrt4_rnd", rnd1, 1);
    check_val("sqrt4_s", s1, 0);
    check_val("sqrt4_inv", inv1, 0);

    set_op(0, 8'h82, 8'h90, 0, 0, 0, 0);
    issue();
    wait_valid(1'b0, lat);
    check_val("sqrt9_lat", lat, 12);
    check_val("sqrt9_e", e1, 8'h80);
    check_val("sqrt9_f", f1, 12'hC00);

    run_special("neg_one",  1, 8'h7F, 8'h80, 0, 0, 0, 0, 0, 8'hFF, 12'h400, 1);
    run_special("neg_zero", 1, 8'h00, 8'h00, 0, 1, 0, 0, 1, 8'h00, 12'h000, 0);
    run_special("pos_inf",  0, 8'hFF, 8'h80, 1, 0, 0, 0, 0, 8'hFF, 12'h000, 0);
    run_special("pos_zero", 0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 8'h00, 12'h000, 0);
    run_special("neg_inf",  1, 8'hFF, 8'h80, 1, 0, 0, 0, 0, 8'hFF, 12'h400, 1);
    run_special("sub_pos",  0, 8'h00, 8'h01, 0, 0, 0, 0, 0, 8'h00, 12'h000, 0);
    run_special("snan",     0, 8'hFF, 8'hA0, 0, 0, 1, 0, 0, 8'hFF, 12'h400, 1);
    run_special("sub_neg",  1, 8'h00, 8'h40, 0, 0, 0, 0, 1, 8'h00, 12'h000, 0);
    run_special("qnan",     1, 8'hFF, 8'hC0, 0, 0, 0, 1, 0, 8'hFF, 12'h400, 0);

    // Second request during ITER must be ignored.
    set_op(0, 8'h81, 8'h80, 0, 0, 0, 0);
    issue();
    repeat (3) begin @(posedge clk); #1; end
    set_op(0, 8'h82, 8'h90, 0, 0, 0, 0);
    do_sqrt = 1'b1;
    check_val("ignore_ready", ready1, 0);
    @(posedge clk); #1;
    do_sqrt = 1'b0;
    wait_valid(1'b0, lat);
    check_val("ignore_lat", lat + 4, 12);
    check_val("ignore_f", f1, 12'h800);

    // Request held from the DONE cycle: ignored there, accepted on the next edge.
    set_op(0, 8'h81, 8'h80, 0, 0, 0, 0);
    issue();
    repeat (11) begin @(posedge clk); #1; end
    check_val("done_ready", ready1, 0);
    set_op(0, 8'h82, 8'h90, 0, 0, 0, 0);
    do_sqrt = 1'b1;
    @(posedge clk); #1;
    check_val("b2b_first_valid", valid1, 1);
    check_val("b2b_first_f", f1, 12'h800);
    @(posedge clk); #1;
    do_sqrt = 1'b0;
    check_val("b2b_accepted", ready1, 0);
    wait_valid(1'b0, lat);
    check_val("b2b_lat", lat, 12);
    check_val("b2b_f", f1, 12'hC00);

    // Reset during iteration aborts the operation.
    set_op(0, 8'h80, 8'h80, 0, 0, 0, 0);
    issue();
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("abort_ready", ready1, 1);
    check_val("abort_valid", valid1, 0);
    check_val("abort_e", e1, 0);
    check_val("abort_f", f1, 0);
    check_val("abort_rnd", rnd1, 0);
    check_val("abort_inv", inv1, 0);
    check_val("abort_s", s1, 0);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (valid1) seen++;
    end
    check_val("abort_no_valid", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
